// File: rtl/ascon_block_packer.sv
// Byte-stream to 64-bit block packer for the ASCON AEAD core.
// Bytes are packed big-endian; each block is held with its length and last flag until accepted.
module ascon_block_packer #(
   parameter int MSG_CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 RST,
   input  logic [7:0]           data_in,
   input  logic                 data_valid,
   input  logic                 data_last,
   input  logic                 flush,
   output logic                 data_ready,
   output logic [63:0]          blk_data,
   output logic [3:0]           blk_len,
   output logic                 blk_last,
   output logic                 blk_valid,
   input  logic                 blk_ready,
   output logic [MSG_CNT_W-1:0] msg_bytes
);

   typedef enum logic {S_FILL = 1'b0, S_HOLD = 1'b1} state_e;

   state_e               state_q, state_d;
   logic [3:0]           cnt_q, cnt_d;
   logic [63:0]          asm_q, asm_d;
   logic [63:0]          blk_data_q, blk_data_d;
   logic [3:0]           blk_len_q, blk_len_d;
   logic                 blk_last_q, blk_last_d;
   logic [MSG_CNT_W-1:0] msg_q, msg_d;

   logic        in_fill;
   logic        accept;
   logic        flush_only;
   logic        last_eff;
   logic [3:0]  cnt_inc;
   logic        close_blk;
   logic        hs;
   logic [63:0] asm_wr;

   assign in_fill    = (state_q == S_FILL);
   assign accept     = in_fill & data_valid;
   assign flush_only = in_fill & flush & ~data_valid;
   // flush riding on an accepted byte terminates the message just like data_last
   assign last_eff   = data_last | flush;
   assign cnt_inc    = cnt_q + 4'd1;
   assign close_blk  = (accept & ((cnt_inc == 4'd8) | last_eff)) | flush_only;
   assign hs         = (state_q == S_HOLD) & blk_ready;

   always_comb begin
      asm_wr = asm_q;
      for (int i = 0; i < 8; i++) begin
         if (cnt_q[2:0] == 3'(i)) asm_wr[63-8*i -: 8] = data_in;
      end
   end

   // state register
   always_ff @(posedge clk or posedge RST) begin
      if (RST) state_q <= S_FILL;
      else     state_q <= state_d;
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FILL:  if (close_blk) state_d = S_HOLD;
         S_HOLD:  if (blk_ready) state_d = S_FILL;
         default: state_d = S_FILL;
      endcase
   end

   // output logic
   always_comb begin
      data_ready = 1'b0;
      blk_valid  = 1'b0;
      case (state_q)
         S_FILL:  data_ready = 1'b1;
         S_HOLD:  blk_valid  = 1'b1;
         default: data_ready = 1'b0;
      endcase
   end

   // datapath: the held block registers only load on the FILL->HOLD transition
   always_comb begin
      cnt_d      = cnt_q;
      asm_d      = asm_q;
      blk_data_d = blk_data_q;
      blk_len_d  = blk_len_q;
      blk_last_d = blk_last_q;
      msg_d      = msg_q;
      if (hs) begin
         cnt_d = 4'd0;
         asm_d = 64'd0;
         if (blk_last_q) msg_d = '0;
      end else if (accept) begin
         msg_d = msg_q + MSG_CNT_W'(1);
         if (close_blk) begin
            blk_data_d = asm_wr;
            blk_len_d  = cnt_inc;
            blk_last_d = last_eff;
         end else begin
            asm_d = asm_wr;
            cnt_d = cnt_inc;
         end
      end else if (flush_only) begin
         blk_data_d = asm_q;
         blk_len_d  = cnt_q;
         blk_last_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         cnt_q      <= 4'd0;
         asm_q      <= 64'd0;
         blk_data_q <= 64'd0;
         blk_len_q  <= 4'd0;
         blk_last_q <= 1'b0;
         msg_q      <= '0;
      end else begin
         cnt_q      <= cnt_d;
         asm_q      <= asm_d;
         blk_data_q <= blk_data_d;
         blk_len_q  <= blk_len_d;
         blk_last_q <= blk_last_d;
         msg_q      <= msg_d;
      end
   end

   assign blk_data  = blk_data_q;
   assign blk_len   = blk_len_q;
   assign blk_last  = blk_last_q;
   assign msg_bytes = msg_q;

endmodule

// File: tb/tb_ascon_block_packer.sv
// Scoreboard bench for ascon_block_packer: a byte-list reference model predicts blocks,
// a monitor compares every presented block and the handshake/counter outputs each cycle.
module tb_ascon_block_packer;

   localparam int MW = 10;

   logic          clk = 1'b0;
   logic          RST;
   logic [7:0]    data_in;
   logic          data_valid;
   logic          data_last;
   logic          flush;
   logic          data_ready;
   logic [63:0]   blk_data;
   logic [3:0]    blk_len;
   logic          blk_last;
   logic          blk_valid;
   logic          blk_ready;
   logic [MW-1:0] msg_bytes;

   ascon_block_packer #(.MSG_CNT_W(MW)) dut (
      .clk        (clk),
      .RST        (RST),
      .data_in    (data_in),
      .data_valid (data_valid),
      .data_last  (data_last),
      .flush      (flush),
      .data_ready (data_ready),
      .blk_data   (blk_data),
      .blk_len    (blk_len),
      .blk_last   (blk_last),
      .blk_valid  (blk_valid),
      .blk_ready  (blk_ready),
      .msg_bytes  (msg_bytes)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [63:0] d;
      logic [3:0]  len;
      logic        last;
   } blk_t;

   blk_t        exp_q[$];
   logic [7:0]  mbuf[$];
   int          msg_m;
   bit          hold_m;
   bit          hold_last_m;
   int          rdy_pct;
   int          errors = 0;
   int          checks = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // reference: a block is simply the list of bytes collected so far, first byte in the top lane
   task automatic emit(input bit last);
      blk_t b;
      b.d = 64'd0;
      for (int i = 0; i < mbuf.size(); i++) b.d = b.d | ({56'd0, mbuf[i]} << (56 - 8*i));
      b.len  = 4'(mbuf.size());
      b.last = last;
      exp_q.push_back(b);
      mbuf.delete();
      hold_m      = 1'b1;
      hold_last_m = last;
   endtask

   task automatic cycle(input bit v, input logic [7:0] b, input bit l, input bit f,
                        output bit acc, output bit fl);
      bit hs;
      bit rdy;
      rdy = ($urandom_range(0, 99) < rdy_pct);
      @(negedge clk);
      data_valid = v; data_in = b; data_last = l; flush = f; blk_ready = rdy;
      acc = v && data_ready;
      fl  = f && !v && data_ready;
      hs  = hold_m && rdy;
      @(posedge clk);
      if (hs) begin
         hold_m = 1'b0;
         if (hold_last_m) msg_m = 0;
      end else if (acc) begin
         mbuf.push_back(b);
         msg_m = (msg_m + 1) % (1 << MW);
         if (mbuf.size() == 8 || l || f) emit(l || f);
      end else if (fl) begin
         emit(1'b1);
      end
   endtask

   task automatic idle();
      bit a, fl;
      cycle(1'b0, 8'h00, 1'b0, 1'b0, a, fl);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit l, input bit f, output int tries);
      bit a, fl;
      tries = 0;
      do begin
         cycle(1'b1, b, l, f, a, fl);
         tries++;
      end while (!a && tries < 100);
      if (!a) begin
         checks++; errors++;
         $display("FAIL byte_accept_timeout: byte %h not accepted after %0d cycles", b, tries);
      end
   endtask

   task automatic send_flush();
      bit a, fl;
      int tries = 0;
      do begin
         cycle(1'b0, 8'h00, 1'b0, 1'b1, a, fl);
         tries++;
      end while (!fl && tries < 100);
      if (!fl) begin
         checks++; errors++;
         $display("FAIL flush_timeout: flush not taken after %0d cycles", tries);
      end
   endtask

   task automatic drain();
      int n = 0;
      rdy_pct = 100;
      while ((hold_m || exp_q.size() != 0) && n < 50) begin
         idle();
         n++;
      end
      idle();
      check("drain_empty", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      data_valid = 1'b0; data_last = 1'b0; flush = 1'b0; blk_ready = 1'b0;
      #2 RST = 1'b1;
      #1;
      check("rst_blk_valid", blk_valid, 1'b0);
      check("rst_blk_data", blk_data, 64'd0);
      check("rst_blk_len", blk_len, 4'd0);
      check("rst_blk_last", blk_last, 1'b0);
      check("rst_msg_bytes", msg_bytes, 0);
      check("rst_data_ready", data_ready, 1'b1);
      exp_q.delete(); mbuf.delete(); msg_m = 0; hold_m = 1'b0; hold_last_m = 1'b0;
      @(negedge clk);
      #3 RST = 1'b0;
   endtask

   // monitor: checks handshake outputs every cycle and each presented block against the scoreboard
   initial begin
      blk_t e;
      forever begin
         @(negedge clk);
         #1;
         if (RST !== 1'b0) continue;
         check("data_ready", data_ready, !hold_m);
         check("blk_valid", blk_valid, hold_m);
         check("msg_bytes", msg_bytes, 64'(msg_m));
         if (blk_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_block: data %h len %0d with none expected", blk_data, blk_len);
            end else begin
               e = exp_q[0];
               check("blk_data", blk_data, e.d);
               check("blk_len", blk_len, e.len);
               check("blk_last", blk_last, e.last);
               if (blk_ready === 1'b1) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      int t;
      bit a, fl;
      RST = 1'b1; data_in = 8'h00; data_valid = 1'b0; data_last = 1'b0; flush = 1'b0; blk_ready = 1'b0;
      msg_m = 0; hold_m = 1'b0; hold_last_m = 1'b0; rdy_pct = 100;
      do_reset();

      for (int i = 0; i < 8; i++) send_byte(8'(i), i == 7, 1'b0, t);
      drain();

      send_byte(8'hA1, 1'b0, 1'b0, t);
      send_byte(8'hB2, 1'b0, 1'b0, t);
      send_byte(8'hC3, 1'b1, 1'b0, t);
      drain();

      send_flush();
      drain();

      for (int i = 0; i < 11; i++) send_byte(8'($urandom), 1'b0, 1'b0, t);
      send_flush();
      drain();

      // backpressure: full block held, a pending byte waits behind it
      rdy_pct = 100;
      for (int i = 0; i < 8; i++) send_byte(8'h40 + 8'(i), 1'b0, 1'b0, t);
      rdy_pct = 0;
      for (int i = 0; i < 5; i++) cycle(1'b1, 8'h5A, 1'b1, 1'b0, a, fl);
      rdy_pct = 100;
      send_byte(8'h5A, 1'b1, 1'b0, t);
      check("bp_accept_delay", 64'(t), 64'd2);
      drain();

      // reset mid-block, and reset while a block is held
      for (int i = 0; i < 4; i++) send_byte(8'h90 + 8'(i), 1'b0, 1'b0, t);
      do_reset();
      send_byte(8'h11, 1'b1, 1'b0, t);
      drain();
      for (int i = 0; i < 8; i++) send_byte(8'h20 + 8'(i), 1'b0, 1'b0, t);
      rdy_pct = 0;
      idle();
      do_reset();
      rdy_pct = 100;
      send_byte(8'h11, 1'b1, 1'b0, t);
      drain();

      // flush coinciding with a byte acts as data_last
      send_byte(8'h77, 1'b0, 1'b0, t);
      send_byte(8'h88, 1'b0, 1'b1, t);
      drain();

      // counter wrap
      for (int i = 0; i < (1 << MW) - 1; i++) send_byte(8'($urandom), 1'b0, 1'b0, t);
      idle(); idle();
      check("msg_bytes_max", msg_bytes, (1 << MW) - 1);
      send_byte(8'hEE, 1'b0, 1'b0, t);
      idle(); idle();
      check("msg_bytes_wrap", msg_bytes, 64'd0);
      send_flush();
      drain();

      // randomized messages with random gaps, backpressure and terminators
      for (int m = 0; m < 150; m++) begin
         int len;
         int term;
         len  = $urandom_range(0, 20);
         term = $urandom_range(0, 2);
         rdy_pct = $urandom_range(30, 100);
         for (int i = 0; i < len; i++) begin
            bit is_last;
            while ($urandom_range(0, 3) == 0) idle();
            is_last = (i == len - 1) && (term != 0);
            send_byte(8'($urandom), is_last && term == 1, is_last && term == 2, t);
         end
         if (len == 0 || term == 0) send_flush();
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ascon_block_packer.md
# ascon_block_packer

Byte-stream to 64-bit block packer that feeds the ASCON AEAD core's `blockin`/`datalen` inputs. It accepts one byte per cycle over a valid/ready handshake and assembles bytes big-endian into 64-bit blocks. It presents each block with its valid-byte count and a last-block flag, and holds it until the downstream controller accepts it. Zero-padding of unused byte lanes happens here; ASCON `0x80` padding stays with the controller, which uses `blk_len`.

## Interface
Parameters:
- `MSG_CNT_W`, default 16: width of the running per-message byte counter.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `RST`  in  1: asynchronous, active-high reset.
- `data_in`  in  8: input byte.
- `data_valid`  in  1: `data_in` is valid this cycle.
- `data_last`  in  1: the current byte is the last byte of the message. Qualified by `data_valid`.
- `flush`  in  1: ends the message without a byte. Sampled only in FILL.
- `data_ready`  out  1: the packer accepts a byte this cycle.
- `blk_data`  out  64: packed block. The first byte of the block is in `[63:56]`; unused lanes are 0.
- `blk_len`  out  4: number of valid bytes, 0..8.
- `blk_last`  out  1: this is the final block of the message.
- `blk_valid`  out  1: the block outputs are valid and stable.
- `blk_ready`  in  1: the downstream accepts the block.
- `msg_bytes`  out  MSG_CNT_W: bytes accepted so far in the current message. Wraps modulo 2^MSG_CNT_W.

## Operation
- States:
  - FILL: collecting bytes.
  - HOLD: a block is presented downstream.
- Byte accept: a byte is accepted when `data_valid & data_ready`. `data_ready = (state==FILL)`, combinational.
- On accept at lane index `cnt` (0..7):
  - the shift/assembly register writes `data_in` into bits `[63-8*cnt -: 8]`;
  - `cnt` increments;
  - `msg_bytes` increments.
- Leaving FILL for HOLD. The block register, `blk_len`, and `blk_last` are loaded and `blk_valid` is set when any of these occurs:
  - an accepted byte makes `cnt` reach 8: `blk_len`=8, `blk_last`=`data_last`;
  - an accepted byte has `data_last`=1 and `cnt+1` < 8: `blk_len`=`cnt+1`, `blk_last`=1;
  - `flush`=1 with no accepted byte: `blk_len`=`cnt` (0 allowed), `blk_last`=1.
- Flush interaction: when `flush` and an accepted byte coincide, `flush` acts as `data_last` for that byte.
- HOLD exit: on `blk_valid & blk_ready`:
  - the next state is FILL, `cnt` goes to 0, the assembly register is cleared to 0, and `blk_valid` goes to 0;
  - if `blk_last` was 1, `msg_bytes` also clears to 0.
- `blk_data`, `blk_len`, and `blk_last` do not change while `blk_valid`=1 and `blk_ready`=0.
- `data_valid` in HOLD is ignored; the byte is not consumed. `flush` in HOLD is ignored.
- A full 8-byte block with `data_last`=1 is emitted once, with `blk_len`=8 and `blk_last`=1. No extra empty block is generated.
- Empty message: `flush` in FILL with `cnt`=0 emits `blk_len`=0, `blk_last`=1, `blk_data`=0.
- `msg_bytes` wrap: 0xFFFF + 1 gives 0x0000 with no flag.

## Timing
- Reset (asynchronous, while `RST`=1):
  - state = FILL, `cnt` = 0;
  - `blk_data` = 0, `blk_len` = 0, `blk_last` = 0, `blk_valid` = 0, `msg_bytes` = 0;
  - `data_ready` = 1 on the first clock after reset deasserts (combinational from state).
- Reset mid-block: any partial block and any held block are discarded. No output glitches beyond going to the reset values.
- Latency: `blk_valid` rises on the clock edge that accepts the terminating byte or `flush`, i.e. it is visible the cycle after the accept.
- HOLD lasts at least 1 cycle. With `blk_ready` tied high it lasts exactly 1 cycle.
- Best-case throughput: 8 bytes per 9 cycles.
- `data_ready` drops in the same cycle `blk_valid` rises.

## Test plan
- Bytes 0x00..0x07, `data_last` on 0x07, `blk_ready`=1 -> one block 0x0001020304050607, `blk_len`=8, `blk_last`=1, `msg_bytes`=8 while valid, then 0.
- Bytes 0xA1,0xB2,0xC3 with `data_last` on 0xC3 -> block 0xA1B2C30000000000, `blk_len`=3, `blk_last`=1.
- `flush` pulse in idle FILL -> block 0, `blk_len`=0, `blk_last`=1. 11 bytes then `flush` -> first block (`blk_len`=8, `blk_last`=0), then second block (`blk_len`=3, `blk_last`=1).
- Backpressure: hold `blk_ready`=0 for 5 cycles with `data_valid`=1 -> `data_ready`=0 throughout, block outputs stable. The byte is accepted only after the handshake plus 1 cycle.
- Assert `RST` after 4 bytes -> outputs go to reset values immediately. A subsequent message of 0x11 + last -> 0x1100000000000000, `blk_len`=1.
- Preload traffic so `msg_bytes` reaches 0xFFFF, then accept one more byte -> `msg_bytes`=0x0000.
